bus_arbiter_rr: RTL and testbench
=================================

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter N_MASTERS, default 4, number of requesting masters (range 2..32).
REQ-002 Parameter RR_MODE, default 1, arbitration policy: 1 = round-robin, 0 = fixed priority with lowest index highest.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles a grant is held without bus_ack; 0 disables the timeout.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset; synchronous, active-low.
REQ-006 bus_req  input  N_MASTERS  per-master request, level-sensitive.
REQ-007 bus_ack  input  1  current owner releases the bus; sampled only while BUSY.
REQ-008 bus_grant  output  N_MASTERS  registered one-hot-or-zero grant vector.
REQ-009 grant_idx  output  $clog2(N_MASTERS)  index of the granted master; 0 when no grant.
REQ-010 bus_busy  output  1  high while in state BUSY.
REQ-011 timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 FSM states: IDLE and BUSY only; bus_busy SHALL equal (state == BUSY).
REQ-013 Winner, fixed mode: lowest index i with bus_req[i]=1.
REQ-014 Winner, round-robin mode: first i with bus_req[i]=1, searching upward from rr_ptr and wrapping from N_MASTERS-1 to 0.
REQ-015 rr_ptr SHALL update to (granted index + 1) mod N_MASTERS at every grant issue.
REQ-016 IDLE, bus_req != 0 -> at the next edge bus_grant = one-hot(winner), state BUSY, hold counter = 0 (1-cycle latency).
REQ-017 IDLE, bus_req == 0 -> remain IDLE, bus_grant = 0.
REQ-018 BUSY, bus_ack=0, no timeout -> bus_grant and grant_idx SHALL stay stable; counter increments.
REQ-019 BUSY, bus_ack=1, bus_req != 0 -> next edge: grant to the new winner (back-to-back, no idle cycle), counter = 0, stay BUSY.
REQ-020 Under REQ-019 in round-robin mode, a still-requesting current owner SHALL lose to any other requester.
REQ-021 BUSY, bus_ack=1, bus_req == 0 -> next edge: bus_grant = 0, state IDLE.
REQ-022 Timeout (TIMEOUT>0): BUSY, bus_ack=0, counter == TIMEOUT-1 -> next edge: bus_grant = 0, state IDLE, timeout_pulse = 1 for exactly one cycle; rr_ptr stays past the revoked master.
REQ-023 Grant duration: a grant never acked SHALL be held exactly TIMEOUT cycles.
REQ-024 bus_ack and timeout in the same cycle: ack wins, REQ-019/021 apply, no timeout_pulse.
REQ-025 bus_ack while IDLE SHALL be ignored.
REQ-026 A granted master dropping bus_req without bus_ack SHALL NOT change the grant.
REQ-027 bus_grant SHALL never have more than one bit set.
REQ-028 A newly asserted grant bit i SHALL imply bus_req[i]=1 in the preceding cycle.
REQ-029 The hold counter SHALL be wide enough for TIMEOUT-1 and SHALL never wrap.

Reset
REQ-030 reset_n=0 at a rising edge, any state including mid-BUSY -> bus_grant=0, grant_idx=0, bus_busy=0, timeout_pulse=0, state IDLE, rr_ptr=0, counter=0.
REQ-031 Requests present during reset SHALL be arbitrated only at the first edge with reset_n=1, with rr_ptr=0.

Verification (N_MASTERS=4, TIMEOUT=4 unless noted)
REQ-032 RR_MODE=1, after reset, bus_req=1010 -> next cycle bus_grant=0010, grant_idx=1, bus_busy=1.
REQ-033 Continue REQ-032 scenario:
- bus_ack=0 for 2 cycles -> grant stays 0010.
- bus_ack=1 with bus_req=1010 -> grant 1000, grant_idx=3.
- bus_ack=1 again -> grant 0010 (wrap).
REQ-034 RR_MODE=0, same stimulus as REQ-033 -> grant 0010 after every ack.
REQ-035 Timeout: bus_req=0011, bus_ack held 0:
- grant 0001 for exactly 4 cycles, then 0000 with timeout_pulse=1 for one cycle, bus_busy=0.
- next cycle grant 0010.
REQ-036 reset_n=0 for one edge while granted 0100 -> next cycle all outputs 0; after release, bus_req=1111 -> grant 0001.
REQ-037 bus_ack=1 on the counter==3 cycle with bus_req=0 -> grant 0000, timeout_pulse stays 0.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin / fixed-priority bus arbiter with grant timeout
module bus_arbiter_rr #(
  parameter int N_MASTERS = 4,
  parameter int RR_MODE   = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_MASTERS-1:0]         bus_req,
  input  logic                         bus_ack,
  output logic [N_MASTERS-1:0]         bus_grant,
  output logic [$clog2(N_MASTERS)-1:0] grant_idx,
  output logic                         bus_busy,
  output logic                         timeout_pulse
);

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               r_state;
  logic [N_MASTERS-1:0] r_grant;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_tpulse;

  logic [IDX_W-1:0]     w_base;
  logic [IDX_W-1:0]     w_win;
  logic [IDX_W-1:0]     w_next_ptr;
  logic [IDX_W-1:0]     w_j;
  logic [N_MASTERS-1:0] w_win_oh;
  logic                 w_any;
  logic                 w_expire;
  int                   w_sum;

  // Scan candidates in reverse search order so the first match in search order is the last one written.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_sum  = 0;
    w_j    = '0;
    w_base = (RR_MODE != 0) ? r_ptr : '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      w_sum = int'(w_base) + k;
      if (w_sum >= N_MASTERS) w_sum = w_sum - N_MASTERS;
      w_j = IDX_W'(w_sum);
      if (bus_req[w_j]) begin
        w_any = 1'b1;
        w_win = w_j;
      end
    end
  end

  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
    w_next_ptr      = (int'(w_win) == N_MASTERS - 1) ? '0 : w_win + 1'b1;
  end

  assign w_expire = (TIMEOUT > 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_idx    <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_tpulse <= 1'b0;
    end else begin
      r_tpulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= BUSY;
            r_grant <= w_win_oh;
            r_idx   <= w_win;
            r_ptr   <= w_next_ptr;
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          // Ack has priority over an expiring hold counter.
          if (bus_ack) begin
            r_cnt <= '0;
            if (w_any) begin
              r_grant <= w_win_oh;
              r_idx   <= w_win;
              r_ptr   <= w_next_ptr;
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
              r_idx   <= '0;
            end
          end else if (w_expire) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_tpulse <= 1'b1;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) assert ($onehot0(r_grant));
  end

  assign bus_grant     = r_grant;
  assign grant_idx     = r_idx;
  assign bus_busy      = (r_state == BUSY);
  assign timeout_pulse = r_tpulse;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed bench for bus_arbiter_rr, round-robin and fixed instances side by side
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       ack = 1'b0;

  logic [3:0] g_rr, g_fx;
  logic [1:0] i_rr, i_fx;
  logic       b_rr, b_fx, t_rr, t_fx;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.N_MASTERS(4), .RR_MODE(1), .TIMEOUT(4)) u_rr (
    .clk(clk), .reset_n(reset_n), .bus_req(req), .bus_ack(ack),
    .bus_grant(g_rr), .grant_idx(i_rr), .bus_busy(b_rr), .timeout_pulse(t_rr));

  bus_arbiter_rr #(.N_MASTERS(4), .RR_MODE(0), .TIMEOUT(4)) u_fx (
    .clk(clk), .reset_n(reset_n), .bus_req(req), .bus_ack(ack),
    .bus_grant(g_fx), .grant_idx(i_fx), .bus_busy(b_fx), .timeout_pulse(t_fx));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 4'b0000; ack = 1'b0;
    tick(); tick();
    vec++; if (g_rr !== 4'b0000) begin miss++; $display("FAIL reset_grant_rr: got %b want 0000", g_rr); end
    vec++; if (i_rr !== 2'd0) begin miss++; $display("FAIL reset_idx_rr: got %0d want 0", i_rr); end
    vec++; if (b_rr !== 1'b0) begin miss++; $display("FAIL reset_busy_rr: got %b want 0", b_rr); end
    vec++; if (t_rr !== 1'b0) begin miss++; $display("FAIL reset_tpulse_rr: got %b want 0", t_rr); end
    vec++; if (g_fx !== 4'b0000) begin miss++; $display("FAIL reset_grant_fx: got %b want 0000", g_fx); end
    reset_n = 1'b1;
    tick();
    vec++; if (b_rr !== 1'b0) begin miss++; $display("FAIL idle_no_req_busy: got %b want 0", b_rr); end
  endtask

  task automatic test_rr_basic();
    req = 4'b1010; ack = 1'b0;
    tick();
    vec++; if (g_rr !== 4'b0010) begin miss++; $display("FAIL first_grant_rr: got %b want 0010", g_rr); end
    vec++; if (i_rr !== 2'd1) begin miss++; $display("FAIL first_idx_rr: got %0d want 1", i_rr); end
    vec++; if (b_rr !== 1'b1) begin miss++; $display("FAIL first_busy_rr: got %b want 1", b_rr); end
    vec++; if (g_fx !== 4'b0010) begin miss++; $display("FAIL first_grant_fx: got %b want 0010", g_fx); end
    for (int c = 0; c < 2; c++) begin
      tick();
      vec++; if (g_rr !== 4'b0010) begin miss++; $display("FAIL hold_grant_rr[%0d]: got %b want 0010", c, g_rr); end
    end
    ack = 1'b1;
    tick();
    vec++; if (g_rr !== 4'b1000) begin miss++; $display("FAIL ack1_grant_rr: got %b want 1000", g_rr); end
    vec++; if (i_rr !== 2'd3) begin miss++; $display("FAIL ack1_idx_rr: got %0d want 3", i_rr); end
    vec++; if (g_fx !== 4'b0010) begin miss++; $display("FAIL ack1_grant_fx: got %b want 0010", g_fx); end
    tick();
    vec++; if (g_rr !== 4'b0010) begin miss++; $display("FAIL ack2_wrap_rr: got %b want 0010", g_rr); end
    vec++; if (g_fx !== 4'b0010) begin miss++; $display("FAIL ack2_grant_fx: got %b want 0010", g_fx); end
    req = 4'b0000;
    tick();
    vec++; if (g_rr !== 4'b0000 || b_rr !== 1'b0) begin miss++; $display("FAIL release_rr: got %b/%b want 0000/0", g_rr, b_rr); end
    vec++; if (g_fx !== 4'b0000 || b_fx !== 1'b0) begin miss++; $display("FAIL release_fx: got %b/%b want 0000/0", g_fx, b_fx); end
    ack = 1'b0;
  endtask

  task automatic test_ack_idle();
    ack = 1'b1; req = 4'b0000;
    tick();
    vec++; if (g_rr !== 4'b0000 || b_rr !== 1'b0) begin miss++; $display("FAIL ack_idle_rr: got %b/%b want 0000/0", g_rr, b_rr); end
    ack = 1'b0;
  endtask

  task automatic test_timeout();
    req = 4'b0011; ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      vec++; if (g_rr !== 4'b0001) begin miss++; $display("FAIL to_hold_rr[%0d]: got %b want 0001", c, g_rr); end
      vec++; if (t_rr !== 1'b0) begin miss++; $display("FAIL to_early_pulse[%0d]: got %b want 0", c, t_rr); end
    end
    tick();
    vec++; if (g_rr !== 4'b0000) begin miss++; $display("FAIL to_revoke_rr: got %b want 0000", g_rr); end
    vec++; if (t_rr !== 1'b1) begin miss++; $display("FAIL to_pulse_rr: got %b want 1", t_rr); end
    vec++; if (b_rr !== 1'b0) begin miss++; $display("FAIL to_busy_rr: got %b want 0", b_rr); end
    vec++; if (t_fx !== 1'b1 || g_fx !== 4'b0000) begin miss++; $display("FAIL to_revoke_fx: got %b/%b want 1/0000", t_fx, g_fx); end
    tick();
    vec++; if (g_rr !== 4'b0010) begin miss++; $display("FAIL to_next_rr: got %b want 0010", g_rr); end
    vec++; if (t_rr !== 1'b0) begin miss++; $display("FAIL to_pulse_width: got %b want 0", t_rr); end
    vec++; if (g_fx !== 4'b0001) begin miss++; $display("FAIL to_next_fx: got %b want 0001", g_fx); end
    req = 4'b0000; ack = 1'b1;
    tick();
    vec++; if (g_rr !== 4'b0000 || g_fx !== 4'b0000) begin miss++; $display("FAIL to_cleanup: got %b/%b want 0000/0000", g_rr, g_fx); end
    ack = 1'b0;
  endtask

  task automatic test_ack_at_timeout();
    req = 4'b0001; ack = 1'b0;
    tick();
    vec++; if (g_rr !== 4'b0001) begin miss++; $display("FAIL at_grant_rr: got %b want 0001", g_rr); end
    req = 4'b0000;
    tick();
    vec++; if (g_rr !== 4'b0001) begin miss++; $display("FAIL drop_req_hold: got %b want 0001", g_rr); end
    tick(); tick();
    vec++; if (g_rr !== 4'b0001) begin miss++; $display("FAIL at_cnt3_hold: got %b want 0001", g_rr); end
    ack = 1'b1;
    tick();
    vec++; if (g_rr !== 4'b0000 || b_rr !== 1'b0) begin miss++; $display("FAIL at_ack_release: got %b/%b want 0000/0", g_rr, b_rr); end
    vec++; if (t_rr !== 1'b0 || t_fx !== 1'b0) begin miss++; $display("FAIL at_no_pulse: got %b/%b want 0/0", t_rr, t_fx); end
    ack = 1'b0;
    tick();
    vec++; if (t_rr !== 1'b0) begin miss++; $display("FAIL at_no_late_pulse: got %b want 0", t_rr); end
  endtask

  task automatic test_back_to_back();
    req = 4'b0100; ack = 1'b0;
    tick();
    vec++; if (g_rr !== 4'b0100) begin miss++; $display("FAIL b2b_pre_rr: got %b want 0100", g_rr); end
    reset_n = 1'b0; req = 4'b1111;
    tick();
    vec++; if (g_rr !== 4'b0000 || i_rr !== 2'd0 || b_rr !== 1'b0 || t_rr !== 1'b0) begin
      miss++; $display("FAIL midbusy_reset: got %b/%0d/%b/%b want 0000/0/0/0", g_rr, i_rr, b_rr, t_rr);
    end
    reset_n = 1'b1;
    tick();
    vec++; if (g_rr !== 4'b0001) begin miss++; $display("FAIL post_reset_rr: got %b want 0001", g_rr); end
    vec++; if (g_fx !== 4'b0001) begin miss++; $display("FAIL post_reset_fx: got %b want 0001", g_fx); end
    ack = 1'b1;
    tick();
    vec++; if (g_rr !== 4'b0010 || i_rr !== 2'd1) begin miss++; $display("FAIL b2b1_rr: got %b/%0d want 0010/1", g_rr, i_rr); end
    vec++; if (b_rr !== 1'b1) begin miss++; $display("FAIL b2b1_busy: got %b want 1", b_rr); end
    vec++; if (g_fx !== 4'b0001) begin miss++; $display("FAIL b2b1_fx: got %b want 0001", g_fx); end
    tick();
    vec++; if (g_rr !== 4'b0100 || i_rr !== 2'd2) begin miss++; $display("FAIL b2b2_rr: got %b/%0d want 0100/2", g_rr, i_rr); end
    req = 4'b0000;
    tick();
    vec++; if (g_rr !== 4'b0000 || b_rr !== 1'b0) begin miss++; $display("FAIL b2b_end: got %b/%b want 0000/0", g_rr, b_rr); end
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rr_basic();
    test_ack_idle();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
